// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encodings and
// the canonical NOP injected on redirects and reset.
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_KILL = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, keeps one 32-bit read outstanding on the
// instruction bus and hands fetched words to PD, honouring stalls and redirects.
module fetch
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_if,
    input  logic            jmp,
    input  logic [XLEN-1:0] jmp_addr,
    output logic            i_rd,
    output logic [XLEN-1:0] i_addr,
    input  logic [31:0]     i_data,
    input  logic            i_ack,
    output logic            b_rd_i,
    output logic [31:0]     ir_if,
    output logic [XLEN-1:0] pc_if
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] kill_addr_q;
    logic [31:0]     ibuf_q;
    logic [XLEN-1:0] jmp_tgt;

    assign jmp_tgt = {jmp_addr[XLEN-1:2], 2'b00};

    // Gated by rst_n so the request drops the moment reset is asserted.
    assign i_rd   = rst_n && (state_q != S_HOLD);
    assign i_addr = (state_q == S_KILL) ? kill_addr_q : pc_q;
    assign b_rd_i = i_rd && !i_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            kill_addr_q <= RESET_PC;
            ibuf_q      <= NOP_INSN;
            ir_if       <= NOP_INSN;
            pc_if       <= RESET_PC;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (jmp) begin
                        pc_q  <= jmp_tgt;
                        ir_if <= NOP_INSN;
                        pc_if <= jmp_tgt;
                        if (!i_ack) begin
                            // Keep the in-flight address on the bus until its ack.
                            kill_addr_q <= pc_q;
                            state_q     <= S_KILL;
                        end
                    end else if (i_ack) begin
                        if (!stall_if) begin
                            ir_if <= i_data;
                            pc_if <= pc_q;
                            pc_q  <= pc_q + XLEN'(4);
                        end else begin
                            ibuf_q  <= i_data;
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (jmp) begin
                        pc_q    <= jmp_tgt;
                        ir_if   <= NOP_INSN;
                        pc_if   <= jmp_tgt;
                        state_q <= S_REQ;
                    end else if (!stall_if) begin
                        ir_if   <= ibuf_q;
                        pc_if   <= pc_q;
                        pc_q    <= pc_q + XLEN'(4);
                        state_q <= S_REQ;
                    end
                end
                S_KILL: begin
                    if (jmp) begin
                        pc_q <= jmp_tgt;
                    end
                    if (i_ack) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch (IF) stage; sits directly upstream of the hazard/stall control unit and the PD stage.
- Owns the PC, issues single-outstanding 32-bit instruction reads on the instruction bus, and presents ir_if/pc_if to PD.
- Obeys stall_if from the control unit; redirects on taken jumps/branches.
- Reports bus-busy as b_rd_i, which the control unit uses to stall the whole pipeline.

Parameters:
- XLEN, 64, width of PC and instruction bus address.
- RESET_PC, 64'h0000_0000_8000_0000, PC value after reset.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_if  in  1  hold ir_if/pc_if; do not advance PC.
- jmp  in  1  single-cycle redirect pulse (branch/jump taken, resolved downstream).
- jmp_addr  in  XLEN  redirect target; bits [1:0] are forced to 0.
- i_rd  out  1  instruction bus read request, level, held until i_ack.
- i_addr  out  XLEN  read address, stable while i_rd=1.
- i_data  in  32  read data, valid only when i_ack=1.
- i_ack  in  1  single-cycle read completion.
- b_rd_i  out  1  read outstanding = i_rd && !i_ack; feeds the control unit's stall_all.
- ir_if  out  32  fetched instruction to PD.
- pc_if  out  XLEN  address of ir_if.

Behaviour:
- Reset (async, immediate):
  - state=S_REQ, pc=RESET_PC, ir_if=NOP (32'h00000013), pc_if=RESET_PC, ibuf=NOP.
  - i_rd is 0 while rst_n=0; the first request is asserted in the first cycle after release.
  - Reset asserted mid-request abandons the request; the bus must tolerate i_rd dropping.
- States:
  - S_REQ: i_rd=1, i_addr=pc.
  - S_HOLD: i_rd=0, fetched word parked in ibuf.
  - S_KILL: i_rd=1, i_addr=old pc; the result will be discarded.
- S_REQ, i_ack=1, no jmp:
  - If !stall_if: ir_if<=i_data, pc_if<=pc, pc<=pc+4, stay S_REQ. i_rd stays 1, so the next request starts the following cycle.
  - If stall_if: ibuf<=i_data, go S_HOLD. ir_if and pc_if are unchanged.
- S_REQ, i_ack=0: wait. ir_if/pc_if hold regardless of stall_if. No bubble is inserted; the control unit stalls downstream via b_rd_i.
- S_HOLD, !stall_if: ir_if<=ibuf, pc_if<=pc, pc<=pc+4, go S_REQ. If stall_if, stay.
- jmp has priority over stall_if and over i_ack. In all cases pc<=jmp_addr&~3 and ir_if<=NOP, pc_if<=jmp_addr&~3.
  - S_REQ with i_ack=0: go S_KILL. The address must not change mid-request.
  - S_REQ with i_ack=1: drop i_data, stay S_REQ. The new request issues next cycle.
  - S_HOLD: drop ibuf, go S_REQ.
  - S_KILL: update pc only. If i_ack arrives in the same cycle, go S_REQ.
- S_KILL, i_ack=1: discard i_data, go S_REQ. ir_if is untouched (already NOP).
- pc+4 wraps modulo 2^XLEN; no exception is raised.
- Exactly one request is outstanding at any time. i_addr is always a multiple of 4.
- b_rd_i=0 in S_HOLD and on any i_ack cycle, so the control unit releases stall_all in the same cycle data returns.

Decomposition:
- Shared package holds:
  - NOP_INSN = 32'h00000013.
  - Fetch state encodings S_REQ/S_HOLD/S_KILL (2-bit).
  - XLEN default.
- Single module; no sub-module is natural. The fetch FSM, PC and ibuf are tightly coupled.

Test Plan:
- Reset release, i_ack 2 cycles after every request, stall_if=0:
  - i_addr sequence 8000_0000, 8000_0004, 8000_0008.
  - ir_if/pc_if update on each ack.
  - b_rd_i=1 on non-ack request cycles.
- Ack at 8000_0004 with stall_if=1 for 3 cycles:
  - i_rd=0 and ir_if holds the previous word during the stall.
  - On release, ir_if=data@8000_0004, pc_if=8000_0004, next i_addr=8000_0008.
- jmp to 8000_0103 while a request to 8000_0010 is pending:
  - i_addr stays 8000_0010 until ack, and that data is discarded.
  - ir_if=NOP immediately after jmp; next request i_addr=8000_0100.
- jmp in the same cycle as i_ack with stall_if=1:
  - Data is dropped and ir_if=NOP.
  - Next i_addr=target; no S_HOLD entry.
- RESET_PC=FFFF_FFFF_FFFF_FFFC:
  - After the first ack, the next i_addr is 0 (wrap).
- rst_n pulsed low while i_rd=1 mid-request:
  - i_rd drops asynchronously, ir_if=NOP.
  - Fetch restarts at RESET_PC.
